// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed at acceptance, held in pending registers, and committed after a fixed latency.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUout
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_wr;

    logic          is_mul, is_div, is_sdiv;
    logic [63:0]   sprod, uprod;
    logic [31:0]   ua, ub, dvd, dvs, uq, ur;
    logic [31:0]   res_hi, res_lo;

    assign is_mul  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign is_div  = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign is_sdiv = (MDUOp == OP_DIV);
    assign start   = (is_mul || is_div) && (state == IDLE);
    assign busy    = (state == BUSY);

    always_comb begin
        MDUout = '0;
        if (MDUOp == OP_MFHI)
            MDUout = HI;
        else if (MDUOp == OP_MFLO)
            MDUout = LO;
    end

    // Signed divide runs on magnitudes; 0x80000000 / -1 then wraps back to 0x80000000 naturally.
    always_comb begin
        sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        uprod = {32'b0, A} * {32'b0, B};
        ua    = A[31] ? (32'd0 - A) : A;
        ub    = B[31] ? (32'd0 - B) : B;
        dvd   = is_sdiv ? ua : A;
        dvs   = is_sdiv ? ub : B;
        if (dvs == '0)
            dvs = 32'd1;
        uq = dvd / dvs;
        ur = dvd % dvs;
        res_hi = '0;
        res_lo = '0;
        case (MDUOp)
            OP_MULT:  {res_hi, res_lo} = sprod;
            OP_MULTU: {res_hi, res_lo} = uprod;
            OP_DIV: begin
                res_lo = (A[31] ^ B[31]) ? (32'd0 - uq) : uq;
                res_hi = A[31] ? (32'd0 - ur) : ur;
            end
            OP_DIVU: begin
                res_lo = uq;
                res_hi = ur;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = BUSY;
            BUSY:    if (cnt == CW'(1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= !(is_div && (B == '0));
                cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (MDUOp == OP_MTHI) begin
                HI <= A;
            end else if (MDUOp == OP_MTLO) begin
                LO <= A;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: inputs driven on falling edges, outputs sampled away from the rising edge.
module tb_mul_div_unit;

    logic        clk;
    logic        reset_n;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUout;

    int checks = 0;
    int errors = 0;
    int n;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .MDUOp(MDUOp), .A(A), .B(B),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .MDUout(MDUout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op for one rising edge, then return to none on the following falling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_start, input string tag);
        MDUOp = op;
        A     = a;
        B     = b;
        #1;
        check({tag, "_start"}, {31'b0, start}, {31'b0, exp_start});
        @(posedge clk);
        @(negedge clk);
        MDUOp = 4'd0;
    endtask

    // Count falling edges that see busy high, bounded so a stuck unit cannot hang the run.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        MDUOp   = 4'd0;
        A       = '0;
        B       = '0;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // signed and unsigned multiply of the same operands
        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, "mult");
        wait_done(n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFE);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, "multu");
        wait_done(n);
        check("multu_cycles", n, 32'd5);
        check("multu_hi", HI, 32'h1);
        check("multu_lo", LO, 32'hFFFF_FFFE);
        issue(4'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, "mult_min");
        wait_done(n);
        check("mult_min_hi", HI, 32'h4000_0000);
        check("mult_min_lo", LO, 32'h0);

        // divide
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, "div");
        wait_done(n);
        check("div_cycles", n, 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
        issue(4'd4, 32'd7, 32'd2, 1'b1, "divu");
        wait_done(n);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);
        issue(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, "divu_big");
        wait_done(n);
        check("divu_big_lo", LO, 32'h7FFF_FFFC);
        check("divu_big_hi", HI, 32'd1);

        // divide by zero leaves HI/LO alone
        issue(4'd7, 32'h11, 32'd0, 1'b0, "mthi11");
        issue(4'd8, 32'h22, 32'd0, 1'b0, "mtlo22");
        check("mt_busy", {31'b0, busy}, 32'd0);
        issue(4'd3, 32'd9, 32'd0, 1'b1, "divz");
        wait_done(n);
        check("divz_cycles", n, 32'd10);
        check("divz_hi", HI, 32'h11);
        check("divz_lo", LO, 32'h22);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "divovf");
        wait_done(n);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'h0);

        // moves and reads
        issue(4'd7, 32'hDEAD, 32'd0, 1'b0, "mthi");
        check("mthi_hi", HI, 32'hDEAD);
        issue(4'd8, 32'hBEEF, 32'd0, 1'b0, "mtlo");
        check("mtlo_lo", LO, 32'hBEEF);
        check("mtlo_hi", HI, 32'hDEAD);
        MDUOp = 4'd5;
        #1;
        check("mfhi_out", MDUout, 32'hDEAD);
        check("mfhi_start", {31'b0, start}, 32'd0);
        MDUOp = 4'd6;
        #1;
        check("mflo_out", MDUout, 32'hBEEF);
        MDUOp = 4'd0;
        #1;
        check("none_out", MDUout, 32'h0);
        @(negedge clk);

        // ops presented while busy are ignored; mflo still sees the old LO
        issue(4'd1, 32'd3, 32'd4, 1'b1, "mult34");
        issue(4'd8, 32'd5, 32'd0, 1'b0, "mtlo_busy");
        issue(4'd2, 32'd100, 32'd100, 1'b0, "multu_busy");
        MDUOp = 4'd6;
        #1;
        check("mflo_busy", MDUout, 32'hBEEF);
        MDUOp = 4'd0;
        wait_done(n);
        check("mult34_cycles", n, 32'd3);
        check("mult34_lo", LO, 32'd12);
        check("mult34_hi", HI, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("mult34_idle", {31'b0, busy}, 32'd0);
        check("mult34_lo_hold", LO, 32'd12);

        // asynchronous reset in the middle of a divide
        issue(4'd3, 32'd100, 32'd7, 1'b1, "div_abort");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", HI, 32'h0);
        check("abort_lo", LO, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_hold_hi", HI, 32'h0);
        check("abort_hold_lo", LO, 32'h0);
        issue(4'd1, 32'h0001_0000, 32'h0001_0000, 1'b1, "mult_post");
        wait_done(n);
        check("post_cycles", n, 32'd5);
        check("post_hi", HI, 32'h1);
        check("post_lo", LO, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
